alu_pipe: RTL and testbench

//  Pipelined, width-parametrised successor to the datapath ALU.
//  Two register stages with valid/ready handshake at both ends.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 37 +++
 rtl/alu_pipe.sv | 104 ++++++++++
 tb/tb_alu_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op encoding and flag bit layout.
// Flag vector width depends on ALU_PIPE_FLAGS_EN (N/V present only when defined).
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 2;

`ifdef ALU_PIPE_FLAGS_EN
  localparam int unsigned FLAG_W = 3;
`else
  localparam int unsigned FLAG_W = 1;
`endif

endpackage

// File: rtl/alu_core.sv
// Combinational op/flag logic sitting between the two pipeline stages.
// N and V are produced only when ALU_PIPE_FLAGS_EN is defined.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  alu_op_e           i_op,
  output logic [WIDTH-1:0]  o_result,
  output logic [FLAG_W-1:0] o_flags
);

  always_comb begin
    o_result = '0;
    o_flags  = '0;
    case (i_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a + ~i_b + WIDTH'(1);
      ALU_AND: o_result = i_a & i_b;
      ALU_NOT: o_result = ~i_b;
    endcase
    o_flags[FLAG_Z] = ~|o_result;
`ifdef ALU_PIPE_FLAGS_EN
    o_flags[FLAG_N] = o_result[WIDTH-1];
    case (i_op)
      ALU_ADD: o_flags[FLAG_V] = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                                 (o_result[WIDTH-1] != i_a[WIDTH-1]);
      ALU_SUB: o_flags[FLAG_V] = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                                 (o_result[WIDTH-1] != i_a[WIDTH-1]);
      default: o_flags[FLAG_V] = 1'b0;
    endcase
`endif
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both ends and a sideband tag.
// Define ALU_PIPE_FLAGS_EN to add the N (sign) and V (signed overflow) outputs.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [1:0]       ALUop,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [TAG_W-1:0] out_tag,
`ifdef ALU_PIPE_FLAGS_EN
  output logic             N,
  output logic             V,
`endif
  output logic             Z
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  alu_op_e          r_s1_op;
  logic [TAG_W-1:0] r_s1_tag;

  logic              r_s2_valid;
  logic [WIDTH-1:0]  r_s2_res;
  logic [TAG_W-1:0]  r_s2_tag;
  logic [FLAG_W-1:0] r_s2_flags;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic [WIDTH-1:0]  w_res;
  logic [FLAG_W-1:0] w_flags;

  // Each stage may load whenever it is empty or its contents leave this cycle,
  // so a full stream with out_ready high never inserts bubbles.
  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= ALU_ADD;
      r_s1_tag   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a   <= Ain;
        r_s1_b   <= Bin;
        r_s1_op  <= alu_op_e'(ALUop);
        r_s1_tag <= in_tag;
      end
    end
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_op     (r_s1_op),
    .o_result (w_res),
    .o_flags  (w_flags)
  );

  // Result registers only load on a real transfer, so data stays frozen while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
      r_s2_tag   <= '0;
      r_s2_flags <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_res   <= w_res;
        r_s2_tag   <= r_s1_tag;
        r_s2_flags <= w_flags;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out       = r_s2_res;
  assign out_tag   = r_s2_tag;
  assign Z         = r_s2_flags[FLAG_Z];
`ifdef ALU_PIPE_FLAGS_EN
  assign N         = r_s2_flags[FLAG_N];
  assign V         = r_s2_flags[FLAG_V];
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe; N/V checks compile in with ALU_PIPE_FLAGS_EN.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic [1:0]  ALUop;
  logic [2:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [2:0]  out_tag;
  logic        Z;
`ifdef ALU_PIPE_FLAGS_EN
  logic        N;
  logic        V;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  alu_pipe #(
    .WIDTH(16),
    .TAG_W(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Ain       (Ain),
    .Bin       (Bin),
    .ALUop     (ALUop),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_tag   (out_tag),
`ifdef ALU_PIPE_FLAGS_EN
    .N         (N),
    .V         (V),
`endif
    .Z         (Z)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op, input logic [2:0] tag);
    in_valid = v;
    Ain      = a;
    Bin      = b;
    ALUop    = op;
    in_tag   = tag;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (out !== 16'h0000) $display("FAIL rst_out: got %h expected 0000", out);
    else n_pass++;
    n_checks++;
    if (out_tag !== 3'd0) $display("FAIL rst_out_tag: got %0d expected 0", out_tag);
    else n_pass++;
    n_checks++;
    if (Z !== 1'b0) $display("FAIL rst_Z: got %b expected 0", Z);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(1'b1, 16'd5, 16'd7, 2'b00, 3'd3);
    step();
    drive(1'b0, 16'd0, 16'd0, 2'b00, 3'd0);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL add_early_valid: got %b expected 0", out_valid);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out !== 16'd12 || out_tag !== 3'd3 || Z !== 1'b0)
      $display("FAIL add_5_7: got v=%b out=%0d tag=%0d Z=%b expected v=1 out=12 tag=3 Z=0",
               out_valid, out, out_tag, Z);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL add_drain: got v=%b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 16'd45, 16'd45, 2'b01, 3'd1);
    step();
    drive(1'b1, 16'd10, 16'd3, 2'b01, 3'd2);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    step();
    drive(1'b0, 16'd0, 16'd0, 2'b00, 3'd0);
    n_checks++;
    if (out_valid !== 1'b1 || out !== 16'd0 || Z !== 1'b1 || out_tag !== 3'd1)
      $display("FAIL sub_45_45: got v=%b out=%0d Z=%b tag=%0d expected v=1 out=0 Z=1 tag=1",
               out_valid, out, Z, out_tag);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out !== 16'd7 || Z !== 1'b0 || out_tag !== 3'd2)
      $display("FAIL sub_10_3: got v=%b out=%0d Z=%b tag=%0d expected v=1 out=7 Z=0 tag=2",
               out_valid, out, Z, out_tag);
    else n_pass++;
    step();
  endtask

  task automatic test_logic();
    out_ready = 1'b1;
    drive(1'b1, 16'd15, 16'd60, 2'b10, 3'd4);
    step();
    drive(1'b1, 16'h1234, 16'h00FF, 2'b11, 3'd5);
    step();
    drive(1'b0, 16'd0, 16'd0, 2'b00, 3'd0);
    n_checks++;
    if (out_valid !== 1'b1 || out !== 16'd12 || out_tag !== 3'd4)
      $display("FAIL and_15_60: got v=%b out=%0d tag=%0d expected v=1 out=12 tag=4",
               out_valid, out, out_tag);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out !== 16'hFF00 || out_tag !== 3'd5 || Z !== 1'b0)
      $display("FAIL not_00ff: got v=%b out=%h tag=%0d Z=%b expected v=1 out=ff00 tag=5 Z=0",
               out_valid, out, out_tag, Z);
    else n_pass++;
    step();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1'b1, 16'd1, 16'd2, 2'b00, 3'd1);
    step();
    drive(1'b1, 16'd3, 16'd4, 2'b00, 3'd2);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL stall_ready_2nd: got %b expected 1", in_ready);
    else n_pass++;
    step();
    drive(1'b1, 16'd5, 16'd6, 2'b00, 3'd3);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL stall_ready_full: got %b expected 0", in_ready);
    else n_pass++;
    for (int unsigned i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out !== 16'd3 || out_tag !== 3'd1 || in_ready !== 1'b0)
        $display("FAIL stall_hold%0d: got v=%b out=%0d tag=%0d rdy=%b expected v=1 out=3 tag=1 rdy=0",
                 i, out_valid, out, out_tag, in_ready);
      else n_pass++;
      if (i < 2) step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b expected 1", in_ready);
    else n_pass++;
    step();
    drive(1'b0, 16'd0, 16'd0, 2'b00, 3'd0);
    n_checks++;
    if (out_valid !== 1'b1 || out !== 16'd7 || out_tag !== 3'd2)
      $display("FAIL stall_out2: got v=%b out=%0d tag=%0d expected v=1 out=7 tag=2",
               out_valid, out, out_tag);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out !== 16'd11 || out_tag !== 3'd3)
      $display("FAIL stall_out3: got v=%b out=%0d tag=%0d expected v=1 out=11 tag=3",
               out_valid, out, out_tag);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL stall_no_dup: got v=%b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    drive(1'b1, 16'h7FFF, 16'h0001, 2'b00, 3'd6);
    step();
    drive(1'b1, 16'h0000, 16'h0001, 2'b01, 3'd7);
    step();
    drive(1'b1, 16'hFFFF, 16'h0001, 2'b00, 3'd0);
    n_checks++;
    if (out !== 16'h8000 || out_tag !== 3'd6) $display("FAIL ovf_add: got out=%h tag=%0d expected 8000 tag=6", out, out_tag);
    else n_pass++;
`ifdef ALU_PIPE_FLAGS_EN
    n_checks++;
    if (N !== 1'b1 || V !== 1'b1) $display("FAIL ovf_add_NV: got N=%b V=%b expected N=1 V=1", N, V);
    else n_pass++;
`endif
    step();
    drive(1'b0, 16'd0, 16'd0, 2'b00, 3'd0);
    n_checks++;
    if (out !== 16'hFFFF || Z !== 1'b0) $display("FAIL sub_0_1: got out=%h Z=%b expected ffff Z=0", out, Z);
    else n_pass++;
`ifdef ALU_PIPE_FLAGS_EN
    n_checks++;
    if (N !== 1'b1 || V !== 1'b0) $display("FAIL sub_0_1_NV: got N=%b V=%b expected N=1 V=0", N, V);
    else n_pass++;
`endif
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out !== 16'h0000 || Z !== 1'b1)
      $display("FAIL carry_drop: got v=%b out=%h Z=%b expected v=1 out=0000 Z=1", out_valid, out, Z);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(1'b1, 16'd100, 16'd1, 2'b00, 3'd5);
    step();
    drive(1'b1, 16'd200, 16'd2, 2'b00, 3'd6);
    step();
    drive(1'b0, 16'd0, 16'd0, 2'b00, 3'd0);
    n_checks++;
    if (out_valid !== 1'b1 || out !== 16'd101) $display("FAIL mid_pre: got v=%b out=%0d expected v=1 out=101", out_valid, out);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out !== 16'd0 || out_tag !== 3'd0)
      $display("FAIL mid_async: got v=%b out=%0d tag=%0d expected v=0 out=0 tag=0", out_valid, out, out_tag);
    else n_pass++;
    step();
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL mid_stale%0d: got v=%b expected 0", i, out_valid);
      else n_pass++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 2'b00, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    step();
    test_add();
    test_back_to_back();
    test_logic();
    test_stall();
    test_flags();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
